// File: rtl/irb_pkg.sv
// Shared constants and types for the inverted-residual-block datapath.
// Holds the FMO tile geometry and the read-out stage FSM encoding.
package irb_pkg;

    localparam int PX_W             = 8;
    localparam int FMO_N_ELEM       = 16;
    localparam int FMO_DRAIN_FIFO_D = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        FIN
    } fmo_drain_state_t;

endpackage

// File: rtl/fmo_drain_if.sv
// Pixel output stream of the FMO drain stage.
// valid/ready handshake with last-beat marking.
interface fmo_drain_if
    import irb_pkg::*;
#(
    parameter int W = PX_W
);

    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/fmo_drain_fifo.sv
// Small synchronous FIFO buffering drained pixels.
// Head is visible combinationally; count feeds the read credit check.
module fmo_drain_fifo
    import irb_pkg::*;
#(
    parameter int  W  = PX_W,
    parameter int  D  = FMO_DRAIN_FIFO_D,
    localparam int PW = (D > 1) ? $clog2(D) : 1,
    localparam int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  mem [D];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign do_push = push && (count != CW'(D));
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rp];

    // pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= inc(wp);
            if (do_pop)  rp <= inc(rp);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // storage array, no reset needed: reads are gated by count
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end

endmodule

// File: rtl/fmo_drain.sv
// FMO tile RAM read-out: sweeps addresses, absorbs RAM latency, streams pixels.
// FMO_DRAIN_CLR_EN: zero each location right after it is read.
module fmo_drain
    import irb_pkg::*;
#(
    parameter int PX_W       = irb_pkg::PX_W,
    parameter int FMO_N_ELEM = irb_pkg::FMO_N_ELEM,
    parameter int AW         = $clog2(FMO_N_ELEM + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW-1:0]   n_elem,
    output logic [AW-1:0]   ram_addr,
    output logic            ram_write,
    output logic [PX_W-1:0] ram_data,
    input  logic [PX_W-1:0] ram_res,
    fmo_drain_if.master     m,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(FMO_DRAIN_FIFO_D + 1);

    fmo_drain_state_t state;
    fmo_drain_state_t nxt;

    logic [AW-1:0]   n_q;
    logic [AW-1:0]   rd_cnt;
    logic [AW-1:0]   out_cnt;
    logic [AW-1:0]   addr_q;
    logic            tag;
    logic            clr_q;
    logic            issue;
    logic            credit;
    logic            drained;
    logic            pop;
    logic [CW-1:0]   fcnt;
    logic            fempty;
    logic [PX_W-1:0] fhead;

    fmo_drain_fifo #(
        .W (PX_W),
        .D (FMO_DRAIN_FIFO_D)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tag),
        .wdata (ram_res),
        .pop   (pop),
        .rdata (fhead),
        .count (fcnt),
        .empty (fempty)
    );

    // a read may only go out if its data is guaranteed a FIFO slot
    assign credit = ({1'b0, fcnt} + {{CW{1'b0}}, tag})
                  < (CW + 1)'(FMO_DRAIN_FIFO_D);
    assign issue  = (state == RUN) && (rd_cnt != n_q)
                  && credit && !clr_q;
    assign pop    = m.m_valid && m.m_ready;

    // exit FLUSH on the edge that pops the final pixel
    assign drained = !tag && !clr_q
                   && (fempty || ((fcnt == CW'(1)) && pop));

    assign ram_addr  = issue ? rd_cnt : addr_q;
    assign ram_data  = '0;
    assign ram_write = clr_q;

    assign m.m_valid = !fempty;
    assign m.m_data  = fempty ? '0 : fhead;
    assign m.m_last  = m.m_valid && (out_cnt == n_q - 1'b1);

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // next-state decode
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = (n_elem == '0) ? FIN : RUN;
            RUN:     if (rd_cnt == n_q) nxt = FLUSH;
            FLUSH:   if (drained) nxt = FIN;
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // sweep counters, held address and read-tag pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q     <= '0;
            rd_cnt  <= '0;
            out_cnt <= '0;
            addr_q  <= '0;
            tag     <= 1'b0;
        end else begin
            tag <= issue;
            if (state == IDLE && start) begin
                n_q     <= n_elem;
                rd_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (issue) begin
                    rd_cnt <= rd_cnt + 1'b1;
                    addr_q <= rd_cnt;
                end
                if (pop) out_cnt <= out_cnt + 1'b1;
            end
        end
    end

`ifdef FMO_DRAIN_CLR_EN
    // clear-write slot follows every read at the same address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clr_q <= 1'b0;
        else        clr_q <= issue;
    end
`else
    assign clr_q = 1'b0;
`endif

endmodule

// File: tb/tb_fmo_drain.sv
// Directed bench for fmo_drain with a registered-read RAM model.
// Honours FMO_DRAIN_CLR_EN for beat spacing and RAM clearing.
module tb_fmo_drain;
    import irb_pkg::*;

    localparam int AW = $clog2(FMO_N_ELEM + 1);
    localparam int MD = 1 << AW;
`ifdef FMO_DRAIN_CLR_EN
    localparam int SP  = 2;
    localparam bit CLR = 1'b1;
`else
    localparam int SP  = 1;
    localparam bit CLR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   n_elem = '0;
    logic [AW-1:0]   ram_addr;
    logic            ram_write;
    logic [PX_W-1:0] ram_data;
    logic [PX_W-1:0] ram_res;
    logic            busy;
    logic            done;

    fmo_drain_if m_if ();

    fmo_drain dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_elem    (n_elem),
        .ram_addr  (ram_addr),
        .ram_write (ram_write),
        .ram_data  (ram_data),
        .ram_res   (ram_res),
        .m         (m_if),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rdy_mode = 0;
    bit init_req = 1'b0;
    bit mon_clr = 1'b0;

    logic [PX_W-1:0] mem [MD];

    // RAM model: read-first, one-cycle registered read
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < MD; i++) mem[i] <= PX_W'(i + 10);
        end else if (ram_write) begin
            mem[ram_addr] <= ram_data;
        end
        ram_res <= mem[ram_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // downstream ready: steady high, or a 1,0,0,1 pattern
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) m_if.m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        else               m_if.m_ready = 1'b1;
    end

    int beat_d[$];
    int beat_l[$];
    int beat_c[$];
    int done_c[$];
    int max_addr = 0;
    int stab_err = 0;
    logic            pv = 1'b0;
    logic [PX_W-1:0] pd = '0;

    // monitor: record handshakes, done pulses, address range, stall stability
    always @(negedge clk) begin
        if (mon_clr) begin
            beat_d.delete();
            beat_l.delete();
            beat_c.delete();
            done_c.delete();
            max_addr = 0;
            stab_err = 0;
            pv = 1'b0;
        end else begin
            if (m_if.m_valid && m_if.m_ready) begin
                beat_d.push_back(int'(m_if.m_data));
                beat_l.push_back(int'(m_if.m_last));
                beat_c.push_back(cyc);
            end
            if (done) done_c.push_back(cyc);
            if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
            if (pv && (!m_if.m_valid || m_if.m_data != pd)) stab_err++;
            pv = m_if.m_valid && !m_if.m_ready && rst_n;
            pd = m_if.m_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic init_mem();
        @(posedge clk);
        #1 init_req = 1'b1;
        @(posedge clk);
        #1 init_req = 1'b0;
    endtask

    task automatic start_drain(input int n, output int s);
        @(posedge clk);
        #1;
        start  = 1'b1;
        n_elem = AW'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_c.size() == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_finished"}, 32'(done_c.size() != 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_beats(input string tag, input int n,
                               input int s, input bit timing);
        chk({tag, "_nbeats"}, 32'(beat_d.size()), 32'(n));
        chk({tag, "_ndone"}, 32'(done_c.size()), 32'd1);
        for (int i = 0; i < n && i < beat_d.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), 32'(beat_d[i]), 32'(i + 10));
            chk($sformatf("%s_last%0d", tag, i), 32'(beat_l[i]),
                32'(i == n - 1));
            if (timing)
                chk($sformatf("%s_cyc%0d", tag, i), 32'(beat_c[i]),
                    32'(s + 2 + SP * i));
        end
        if (timing && done_c.size() > 0)
            chk({tag, "_donecyc"}, 32'(done_c[0]),
                32'(s + 2 + SP * (n - 1) + 1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        int k;
        repeat (3) @(posedge clk);
        init_mem();
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(m_if.m_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_write", 32'(ram_write), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // n=5 with ready held high
        clear_mon();
        start_drain(5, s);
        wait_done("t1", 60);
        check_beats("t1", 5, s, 1'b1);
        chk("t1_data_const", 32'(ram_data), 32'd0);

        // n=8 under a stalling consumer
        init_mem();
        clear_mon();
        rdy_mode = 1;
        start_drain(8, s);
        wait_done("t2", 200);
        rdy_mode = 0;
        check_beats("t2", 8, s, 1'b0);
        chk("t2_maxaddr", 32'(max_addr), 32'd7);
        chk("t2_stable", 32'(stab_err), 32'd0);

        // empty drain
        init_mem();
        clear_mon();
        start_drain(0, s);
        wait_done("t3", 20);
        chk("t3_nbeats", 32'(beat_d.size()), 32'd0);
        chk("t3_donecyc", 32'(done_c.size() > 0 ? done_c[0] : -1), 32'(s));

        // start re-pulsed while busy is ignored
        init_mem();
        clear_mon();
        start_drain(3, s);
        @(posedge clk);
        #1;
        start  = 1'b1;
        n_elem = AW'(9);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t4", 60);
        repeat (20) @(posedge clk);
        #1;
        check_beats("t4", 3, s, 1'b0);

        // reset in the middle of a drain
        init_mem();
        clear_mon();
        start_drain(6, s);
        k = 0;
        while (beat_d.size() < 2 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("t5_two_beats", 32'(beat_d.size() >= 2), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_addr", 32'(ram_addr), 32'd0);
        chk("t5_write", 32'(ram_write), 32'd0);
        chk("t5_valid", 32'(m_if.m_valid), 32'd0);
        chk("t5_data", 32'(m_if.m_data), 32'd0);
        chk("t5_last", 32'(m_if.m_last), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        clear_mon();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_nodone", 32'(done_c.size()), 32'd0);
        chk("t5_nobeat", 32'(beat_d.size()), 32'd0);
        init_mem();
        clear_mon();
        start_drain(2, s);
        wait_done("t5b", 40);
        check_beats("t5b", 2, s, 1'b1);

        // n=4, then inspect RAM contents
        init_mem();
        clear_mon();
        start_drain(4, s);
        wait_done("t6", 60);
        check_beats("t6", 4, s, 1'b1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t6_ram%0d", i), 32'(mem[i]),
                CLR ? 32'd0 : 32'(i + 10));
        chk("t6_ram4", 32'(mem[4]), 32'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
